// File: rtl/moa_pkg.sv
// Shared helpers for the moa_acc_pipe multi-operand accumulator.
// Optional overflow reporting is enabled by defining MOA_OVF_EN.
package moa_pkg;

  // Frame delimiters carried alongside each beat through S1.
  typedef struct packed {
    logic first;
    logic last;
  } beat_flags_t;

  // Exact width of a beat total: NOPS operands of WIDTH bits each.
  function automatic int sw_width(input int nops, input int width);
    return width + $clog2(nops);
  endfunction

  // Number of 3:2 counter layers needed to reduce nops vectors to two.
  function automatic int csa_layers(input int nops);
    int n;
    int layers;
    n = nops;
    layers = 0;
    while (n > 2) begin
      n = n - n / 3;
      layers++;
    end
    return layers;
  endfunction

  function automatic bit acc_width_ok(input int accw, input int sw);
    return accw >= sw;
  endfunction

endpackage

// File: rtl/moa_csa_tree.sv
// Combinational NOPS-to-2 carry-save compressor built from 3:2 counter layers.
// The two SW-bit outputs always add to the exact operand total.
module moa_csa_tree
  import moa_pkg::*;
#(
  parameter int NOPS  = 6,
  parameter int WIDTH = 8,
  localparam int SW   = sw_width(NOPS, WIDTH)
) (
  input  logic [NOPS*WIDTH-1:0] ops_i,
  output logic [SW-1:0]         sum_o,
  output logic [SW-1:0]         carry_o
);

  localparam int LAYERS = csa_layers(NOPS);

  // Carries shifted out of the top bit are dropped safely: the true total fits in SW bits.
  always_comb begin : reduce
    logic [SW-1:0] vec [NOPS];
    logic [SW-1:0] nxt [NOPS];
    int n;
    int m;
    int g;
    for (int k = 0; k < NOPS; k++) begin
      vec[k] = SW'(ops_i[k*WIDTH +: WIDTH]);
    end
    n = NOPS;
    for (int l = 0; l < LAYERS; l++) begin
      nxt = '{default: '0};
      g = n / 3;
      m = 0;
      for (int j = 0; j < NOPS / 3; j++) begin
        if (j < g) begin
          nxt[m]     = vec[3*j] ^ vec[3*j+1] ^ vec[3*j+2];
          nxt[m+1]   = ((vec[3*j] & vec[3*j+1]) | (vec[3*j] & vec[3*j+2]) |
                        (vec[3*j+1] & vec[3*j+2])) << 1;
          m = m + 2;
        end
      end
      for (int j = 0; j < NOPS; j++) begin
        if (j >= 3 * g && j < n) begin
          nxt[m] = vec[j];
          m = m + 1;
        end
      end
      vec = nxt;
      n = m;
    end
    sum_o   = vec[0];
    carry_o = vec[1];
  end

endmodule

// File: rtl/moa_acc_pipe.sv
// Pipelined multi-operand frame accumulator: CSA stage S1, then CPA + accumulate into an output register.
// Define MOA_OVF_EN to add the out_ovf port and the sticky per-frame overflow flag.
module moa_acc_pipe
  import moa_pkg::*;
#(
  parameter int NOPS  = 6,
  parameter int WIDTH = 8,
  parameter int ACCW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NOPS*WIDTH-1:0] in_ops,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef MOA_OVF_EN
  output logic                  out_ovf,
`endif
  output logic [ACCW-1:0]       out_sum
);

  localparam int SW = sw_width(NOPS, WIDTH);

  generate
    if (!acc_width_ok(ACCW, SW)) begin : g_bad_accw
      $error("moa_acc_pipe: ACCW must be >= WIDTH + clog2(NOPS)");
    end
    if (NOPS < 2) begin : g_bad_nops
      $error("moa_acc_pipe: NOPS must be >= 2");
    end
  endgenerate

  logic [SW-1:0]   csa_sum;
  logic [SW-1:0]   csa_carry;

  logic            s1_valid_q, s1_valid_d;
  beat_flags_t     s1_flags_q, s1_flags_d;
  logic [SW-1:0]   s1_sum_q, s1_sum_d;
  logic [SW-1:0]   s1_carry_q, s1_carry_d;

  logic [ACCW-1:0] acc_q, acc_d;
  logic            frame_done_q, frame_done_d;
  logic            out_valid_q, out_valid_d;
  logic [ACCW-1:0] out_sum_q, out_sum_d;

  logic [SW-1:0]   beat_total;
  logic            frame_start;
  logic [ACCW-1:0] acc_base;
  logic [ACCW-1:0] acc_next;
  logic            s1_retire;
  logic            beat_accept;

  moa_csa_tree #(
    .NOPS  (NOPS),
    .WIDTH (WIDTH)
  ) u_csa (
    .ops_i   (in_ops),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  assign beat_total  = s1_sum_q + s1_carry_q;
  assign frame_start = s1_flags_q.first | frame_done_q;
  assign acc_base    = frame_start ? '0 : acc_q;

`ifdef MOA_OVF_EN
  logic acc_carry;
  assign {acc_carry, acc_next} = {1'b0, acc_base} + (ACCW+1)'(beat_total);
`else
  assign acc_next = acc_base + ACCW'(beat_total);
`endif

  // A last beat may only retire when the output register is free or being emptied this edge.
  assign s1_retire   = s1_valid_q & (~s1_flags_q.last | ~out_valid_q | out_ready);
  assign in_ready    = ~s1_valid_q | s1_retire;
  assign beat_accept = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_flags_d   = s1_flags_q;
    s1_sum_d     = s1_sum_q;
    s1_carry_d   = s1_carry_q;
    acc_d        = acc_q;
    frame_done_d = frame_done_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;

    if (beat_accept) begin
      s1_valid_d       = 1'b1;
      s1_flags_d.first = in_first;
      s1_flags_d.last  = in_last;
      s1_sum_d         = csa_sum;
      s1_carry_d       = csa_carry;
    end else if (s1_retire) begin
      s1_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s1_retire) begin
      acc_d        = acc_next;
      frame_done_d = s1_flags_q.last;
      if (s1_flags_q.last) begin
        out_valid_d = 1'b1;
        out_sum_d   = acc_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_flags_q   <= '0;
      s1_sum_q     <= '0;
      s1_carry_q   <= '0;
      acc_q        <= '0;
      frame_done_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_flags_q   <= s1_flags_d;
      s1_sum_q     <= s1_sum_d;
      s1_carry_q   <= s1_carry_d;
      acc_q        <= acc_d;
      frame_done_q <= frame_done_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
    end
  end

`ifdef MOA_OVF_EN
  logic ovf_q, ovf_d;
  logic out_ovf_q, out_ovf_d;
  logic ovf_next;

  // Each beat adds less than 2^ACCW, so one carry per addition captures every wrap.
  assign ovf_next = (frame_start ? 1'b0 : ovf_q) | acc_carry;
  assign out_ovf  = out_ovf_q;

  always_comb begin
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf_q;
    if (s1_retire) begin
      ovf_d = ovf_next;
      if (s1_flags_q.last) begin
        out_ovf_d = ovf_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_moa_acc_pipe.sv
// Self-checking bench for moa_acc_pipe: directed steps plus random frames against a frame-level model.
// Builds with or without MOA_OVF_EN.
module tb_moa_acc_pipe;

  localparam int NOPS  = 6;
  localparam int WIDTH = 8;
  localparam int ACCW  = 16;

  typedef struct {
    longint sum;
    bit     ovf;
  } result_t;

  logic                  clk;
  logic                  rstN;
  logic                  inValid;
  logic                  inReady;
  logic [NOPS*WIDTH-1:0] inOps;
  logic                  inFirst;
  logic                  inLast;
  logic                  outValid;
  logic                  outReady;
  logic [ACCW-1:0]       outSum;
`ifdef MOA_OVF_EN
  logic                  outOvf;
`endif

  int      total = 0;
  int      bad = 0;
  int      gotCount = 0;
  bit      randReady = 0;
  result_t expQ[$];
  longint  runSum = 0;
  bit      inFrame = 0;

  moa_acc_pipe #(
    .NOPS  (NOPS),
    .WIDTH (WIDTH),
    .ACCW  (ACCW)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_ops    (inOps),
    .in_first  (inFirst),
    .in_last   (inLast),
    .out_valid (outValid),
    .out_ready (outReady),
`ifdef MOA_OVF_EN
    .out_ovf   (outOvf),
`endif
    .out_sum   (outSum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic longint sumOps(input logic [NOPS*WIDTH-1:0] ops);
    longint s = 0;
    for (int k = 0; k < NOPS; k++) s += longint'(ops[k*WIDTH +: WIDTH]);
    return s;
  endfunction

  // Frame-level reference: a frame restarts on in_first or after a completed frame.
  function automatic void modelBeat(input bit first, input bit last, input logic [NOPS*WIDTH-1:0] ops);
    result_t r;
    if (first || !inFrame) runSum = 0;
    inFrame = 1;
    runSum += sumOps(ops);
    if (last) begin
      r.sum = runSum % (64'd1 << ACCW);
      r.ovf = (runSum >= (64'd1 << ACCW));
      expQ.push_back(r);
      inFrame = 0;
    end
  endfunction

  task automatic applyStimulus(input bit first, input bit last, input logic [NOPS*WIDTH-1:0] ops);
    bit accepted = 0;
    int waitCycles = 0;
    @(negedge clk);
    inValid = 1'b1;
    inFirst = first;
    inLast  = last;
    inOps   = ops;
    while (!accepted && waitCycles <= 200) begin
      if (randReady) outReady = 1'($urandom_range(0, 1));
      #1;
      if (inReady) accepted = 1;
      @(posedge clk);
      if (!accepted) begin
        waitCycles++;
        @(negedge clk);
      end
    end
    #1;
    inValid = 1'b0;
    if (accepted) modelBeat(first, last, ops);
    else checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitResult(input string tag, input longint expected);
    int cycles = 0;
    do begin
      @(negedge clk);
      #1;
      cycles++;
    end while (!outValid && cycles < 30);
    checkOutput({tag, "_valid"}, longint'(outValid), 1);
    checkOutput(tag, longint'(outSum), expected);
  endtask

  // Result collector: every completed output handshake is compared against the model queue.
  always @(negedge clk) begin
    result_t r;
    #2;
    if (rstN && outValid && outReady) begin
      gotCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", longint'(outSum), -1);
      end else begin
        r = expQ.pop_front();
        checkOutput("out_sum", longint'(outSum), r.sum);
`ifdef MOA_OVF_EN
        checkOutput("out_ovf", longint'(outOvf), longint'(r.ovf));
`endif
      end
    end
  end

  initial begin
    logic [NOPS*WIDTH-1:0] ops;
    inValid  = 1'b0;
    inFirst  = 1'b0;
    inLast   = 1'b0;
    inOps    = '0;
    outReady = 1'b1;
    rstN     = 1'b0;
    #1;
    checkOutput("rst_in_ready", longint'(inReady), 1);
    checkOutput("rst_out_valid", longint'(outValid), 0);
    checkOutput("rst_out_sum", longint'(outSum), 0);
`ifdef MOA_OVF_EN
    checkOutput("rst_out_ovf", longint'(outOvf), 0);
`endif
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Single full-scale beat and its latency
    applyStimulus(1, 1, {NOPS{8'hFF}});
    @(negedge clk); #1;
    checkOutput("lat_after_accept", longint'(outValid), 0);
    @(negedge clk); #1;
    checkOutput("lat_next_edge", longint'(outValid), 1);
    checkOutput("t1_sum", longint'(outSum), 16'h05FA);
`ifdef MOA_OVF_EN
    checkOutput("t1_ovf", longint'(outOvf), 0);
`endif

    // Four-beat frame: nothing until the last beat
    for (int b = 0; b < 4; b++) begin
      applyStimulus(b == 0, b == 3, {NOPS{8'h01}});
      if (b < 3) begin
        @(negedge clk); #1;
        checkOutput("t2_no_early_valid", longint'(outValid), 0);
      end
    end
    waitResult("t2_sum", 16'h0018);
    repeat (3) @(negedge clk);

    // Back-pressure: two single-beat frames held behind out_ready=0
    outReady = 1'b0;
    applyStimulus(1, 1, {NOPS{8'h01}});
    applyStimulus(1, 1, {NOPS{8'h02}});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checkOutput("t3_hold_valid", longint'(outValid), 1);
      checkOutput("t3_hold_sum", longint'(outSum), 16'h0006);
      checkOutput("t3_in_ready_low", longint'(inReady), 0);
    end
    outReady = 1'b1;
    @(negedge clk); #1;
    checkOutput("t3_second_sum", longint'(outSum), 16'h000C);
    repeat (3) @(negedge clk);
    checkOutput("t3_drained", longint'(expQ.size()), 0);
    checkOutput("t3_result_count", longint'(gotCount), 4);

    // 50-beat frame wrapping the accumulator
    for (int b = 0; b < 50; b++) applyStimulus(b == 0, b == 49, {NOPS{8'hFF}});
    waitResult("t4_sum", 16'h2AD4);
`ifdef MOA_OVF_EN
    checkOutput("t4_ovf", longint'(outOvf), 1);
`endif
    repeat (3) @(negedge clk);

    // Reset mid-frame with an unaccepted result pending
    outReady = 1'b0;
    applyStimulus(1, 1, {NOPS{8'h03}});
    applyStimulus(1, 0, {NOPS{8'h01}});
    applyStimulus(0, 0, {NOPS{8'h01}});
    @(negedge clk); #1;
    rstN = 1'b0;
    #1;
    checkOutput("t5_rst_in_ready", longint'(inReady), 1);
    checkOutput("t5_rst_out_valid", longint'(outValid), 0);
    checkOutput("t5_rst_out_sum", longint'(outSum), 0);
`ifdef MOA_OVF_EN
    checkOutput("t5_rst_out_ovf", longint'(outOvf), 0);
`endif
    expQ.delete();
    inFrame = 0;
    @(negedge clk);
    rstN = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < NOPS; k++) ops[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    applyStimulus(0, 1, ops);
    waitResult("t5_sum", 16'h0015);
    repeat (3) @(negedge clk);

    // Mid-frame restart discards the partial frame
    gotCount = 0;
    for (int b = 0; b < 3; b++) applyStimulus(b == 0, 0, {NOPS{8'h01}});
    applyStimulus(1, 1, {NOPS{8'h02}});
    waitResult("t6_sum", 16'h000C);
    repeat (3) @(negedge clk);
    checkOutput("t6_result_count", longint'(gotCount), 1);

    // Random frames with random consumer back-pressure
    randReady = 1;
    for (int b = 0; b < 60; b++) begin
      for (int k = 0; k < NOPS; k++) ops[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, ops);
    end
    applyStimulus(0, 1, {NOPS{8'h10}});
    randReady = 0;
    outReady = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rand_drained", longint'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
